// File: rtl/ddr3_loopback_traffic_checker.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_loopback_traffic_checker
// Purpose  : Loopback traffic generator/checker for the DDR3 controller user
//            port. Writes N patterned words over a strided address range,
//            reads them back and checks every returned word against a
//            regenerated expected pattern.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_loopback_traffic_checker #(
  parameter int DQ_BITWIDTH           = 8,
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int MAX_NUM_OF_TEST_DATA  = 256,
  parameter int ERROR_COUNT_BITWIDTH  = 16,
  parameter logic [DQ_BITWIDTH-1:0] LFSR_SEED = {{(DQ_BITWIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [1:0]                                        mode,
  input  logic [$clog2(MAX_NUM_OF_TEST_DATA):0]             num_words,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] base_addr,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] stride,
  output logic                                              write_enable,
  output logic                                              read_enable,
  input  logic                                              write_accept,
  input  logic                                              read_accept,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
  input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
  input  logic                                              data_from_ram_valid,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic [ERROR_COUNT_BITWIDTH-1:0]                   error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_addr
);

  localparam int c_cw = $clog2(MAX_NUM_OF_TEST_DATA) + 1;
  localparam int c_aw = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam logic [c_cw-1:0]        c_max_words = c_cw'(MAX_NUM_OF_TEST_DATA);
  localparam logic [DQ_BITWIDTH-1:0] c_walk_init = DQ_BITWIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state, w_next_state;

  // Run configuration, captured on an accepted start
  logic [1:0]      r_mode;
  logic [c_cw-1:0] r_n;
  logic [c_aw-1:0] r_base;
  logic [c_aw-1:0] r_stride;

  // Request generator: word index doubles as the issue counter of each phase
  logic                   r_write_enable;
  logic                   r_read_enable;
  logic [c_cw-1:0]        r_req_k;
  logic [c_aw-1:0]        r_req_addr;
  logic [DQ_BITWIDTH-1:0] r_req_lfsr;
  logic [DQ_BITWIDTH-1:0] r_req_walk;

  // Expected-pattern generator: advances only on accepted read data
  logic [c_cw-1:0]                 r_chk_k;
  logic [c_aw-1:0]                 r_chk_addr;
  logic [DQ_BITWIDTH-1:0]          r_chk_lfsr;
  logic [DQ_BITWIDTH-1:0]          r_chk_walk;
  logic [ERROR_COUNT_BITWIDTH-1:0] r_error_count;
  logic [c_aw-1:0]                 r_first_error_addr;
  logic                            r_seen_error;

  logic                   w_launch;
  logic [c_cw-1:0]        w_start_n;
  logic                   w_wr_fire;
  logic                   w_rd_fire;
  logic [c_cw-1:0]        w_req_k_inc;
  logic                   w_last_req;
  logic                   w_chk_valid;
  logic [DQ_BITWIDTH-1:0] w_expected;
  logic                   w_mismatch;

  // PRBS step: shift left, feedback from the two top bits
  function automatic logic [DQ_BITWIDTH-1:0] f_lfsr_next(input logic [DQ_BITWIDTH-1:0] s);
    return {s[DQ_BITWIDTH-2:0], s[DQ_BITWIDTH-1] ^ s[DQ_BITWIDTH-2]};
  endfunction

  // Walking one as a rotation equals 1 << (k mod DQ_BITWIDTH) without a divider
  function automatic logic [DQ_BITWIDTH-1:0] f_walk_next(input logic [DQ_BITWIDTH-1:0] s);
    return {s[DQ_BITWIDTH-2:0], s[DQ_BITWIDTH-1]};
  endfunction

  function automatic logic [DQ_BITWIDTH-1:0] f_pattern(
    input logic [1:0]             md,
    input logic [c_cw-1:0]        k,
    input logic [c_aw-1:0]        addr,
    input logic [DQ_BITWIDTH-1:0] lfsr,
    input logic [DQ_BITWIDTH-1:0] walk
  );
    case (md)
      2'd0:    return DQ_BITWIDTH'(k);
      2'd1:    return lfsr;
      2'd2:    return walk;
      default: return DQ_BITWIDTH'(addr);
    endcase
  endfunction

  assign w_launch    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_start_n   = (num_words > c_max_words) ? c_max_words : num_words;
  assign w_wr_fire   = r_write_enable && write_accept;
  assign w_rd_fire   = r_read_enable && read_accept;
  assign w_req_k_inc = r_req_k + c_cw'(1);
  assign w_last_req  = (w_req_k_inc == r_n);

  // Returned data is only meaningful in READ/DRAIN and only until n words arrived
  assign w_chk_valid = data_from_ram_valid && (r_chk_k != r_n) &&
                       ((r_state == S_READ) || (r_state == S_DRAIN));
  assign w_expected  = f_pattern(r_mode, r_chk_k, r_chk_addr, r_chk_lfsr, r_chk_walk);
  assign w_mismatch  = w_chk_valid && (data_from_ram != w_expected);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    pass         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        pass = (r_state == S_DONE) && (r_error_count == '0);
        if (start) w_next_state = (w_start_n == '0) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (w_wr_fire && w_last_req) w_next_state = S_READ;
      end
      S_READ: begin
        busy = 1'b1;
        if (w_rd_fire && w_last_req) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_chk_k == r_n) w_next_state = S_DONE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Capture the run configuration on an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode   <= '0;
      r_n      <= '0;
      r_base   <= '0;
      r_stride <= '0;
    end else if (w_launch) begin
      r_mode   <= mode;
      r_n      <= w_start_n;
      r_base   <= base_addr;
      r_stride <= stride;
    end
  end

  // Request generator: one held request at a time, one idle cycle after each accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_enable <= 1'b0;
      r_read_enable  <= 1'b0;
      r_req_k        <= '0;
      r_req_addr     <= '0;
      r_req_lfsr     <= LFSR_SEED;
      r_req_walk     <= c_walk_init;
    end else if (w_launch) begin
      r_write_enable <= (w_start_n != '0);
      r_read_enable  <= 1'b0;
      r_req_k        <= '0;
      r_req_addr     <= base_addr;
      r_req_lfsr     <= LFSR_SEED;
      r_req_walk     <= c_walk_init;
    end else begin
      case (r_state)
        S_WRITE: begin
          if (w_wr_fire) begin
            r_write_enable <= 1'b0;
            if (w_last_req) begin
              // Rewind for the read phase
              r_req_k    <= '0;
              r_req_addr <= r_base;
              r_req_lfsr <= LFSR_SEED;
              r_req_walk <= c_walk_init;
            end else begin
              r_req_k    <= w_req_k_inc;
              r_req_addr <= r_req_addr + r_stride;
              r_req_lfsr <= f_lfsr_next(r_req_lfsr);
              r_req_walk <= f_walk_next(r_req_walk);
            end
          end else if (!r_write_enable) begin
            r_write_enable <= 1'b1;
          end
        end
        S_READ: begin
          if (w_rd_fire) begin
            r_read_enable <= 1'b0;
            r_req_k       <= w_req_k_inc;
            r_req_addr    <= r_req_addr + r_stride;
          end else if (!r_read_enable) begin
            r_read_enable <= 1'b1;
          end
        end
        default: begin
          r_write_enable <= 1'b0;
          r_read_enable  <= 1'b0;
        end
      endcase
    end
  end

  // Checker: compare each returned word, count mismatches, remember the first
  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk_k            <= '0;
      r_chk_addr         <= '0;
      r_chk_lfsr         <= LFSR_SEED;
      r_chk_walk         <= c_walk_init;
      r_error_count      <= '0;
      r_first_error_addr <= '0;
      r_seen_error       <= 1'b0;
    end else if (w_launch) begin
      r_chk_k            <= '0;
      r_chk_addr         <= base_addr;
      r_chk_lfsr         <= LFSR_SEED;
      r_chk_walk         <= c_walk_init;
      r_error_count      <= '0;
      r_first_error_addr <= '0;
      r_seen_error       <= 1'b0;
    end else if (w_chk_valid) begin
      r_chk_k    <= r_chk_k + c_cw'(1);
      r_chk_addr <= r_chk_addr + r_stride;
      r_chk_lfsr <= f_lfsr_next(r_chk_lfsr);
      r_chk_walk <= f_walk_next(r_chk_walk);
      if (w_mismatch) begin
        if (r_error_count != '1) r_error_count <= r_error_count + ERROR_COUNT_BITWIDTH'(1);
        if (!r_seen_error) begin
          r_first_error_addr <= r_chk_addr;
          r_seen_error       <= 1'b1;
        end
      end
    end
  end

  assign write_enable        = r_write_enable;
  assign read_enable         = r_read_enable;
  assign i_user_data_address = (r_write_enable || r_read_enable) ? r_req_addr : '0;
  assign data_to_ram         = r_write_enable ?
                               f_pattern(r_mode, r_req_k, r_req_addr, r_req_lfsr, r_req_walk) : '0;
  assign error_count         = r_error_count;
  assign first_error_addr    = r_first_error_addr;

endmodule
`default_nettype wire
